ex_stage: RTL and testbench
===========================

Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS32 pipeline. Consumes the decoded ID/EX bundle: aluop, alusel, both operands, destination, write enable.
- Produces the EX result, which feeds the EX/MEM register and the forwarding inputs of decode in the same cycle.
- Adds an iterative 32-cycle DIV/DIVU unit that stalls the pipeline and writes HI/LO.

Parameters:
- DIV_CYCLES, 32, number of radix-2 iteration cycles; must equal the operand width.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset (`RstEnable = 1'b1)
- aluop_i  in  8  operation code (`AluOpBus), from ID/EX
- alusel_i  in  3  result class (`AluSelBus)
- reg1_i  in  32  operand 1: rs, or zero-extended imm/sa
- reg2_i  in  32  operand 2: rt, or immediate
- wd_i  in  5  destination GPR
- wreg_i  in  1  GPR write enable
- wd_o  out  5  destination to EX/MEM and ID forwarding
- wreg_o  out  1  write enable to EX/MEM and ID forwarding
- wdata_o  out  32  result to EX/MEM and ID forwarding
- whilo_o  out  1  one-cycle HI/LO write strobe
- hi_o  out  32  remainder
- lo_o  out  32  quotient
- stallreq_o  out  1  hold PC, IF/ID and ID/EX while high

Behaviour:
- Datapath is combinational, zero latency. wd_o = wd_i.
- Forwarding outputs:
  - wreg_o = wreg_i, except 0 for DIV/DIVU.
  - wdata_o is selected by alusel_i: `EXE_RES_LOGIC, `EXE_RES_SHIFT, otherwise 0.
- Logic (by aluop): OR = reg1|reg2; AND = reg1&reg2; XOR = reg1^reg2; NOR = ~(reg1|reg2). Unknown aluop gives 0.
- Shift: shift amount = reg1_i[4:0], value = reg2_i.
  - SLL is logical left; SRL is logical right.
  - SRA is arithmetic right, replicating reg2_i[31].
  - An amount of 0 passes reg2_i through unchanged.
- During rst: wd_o=0, wreg_o=0, wdata_o=0, whilo_o=0, hi_o=0, lo_o=0, stallreq_o=0.
- Divider FSM states: FREE, BY_ZERO, ON, END. Reset state is FREE with the counter at 0.
  - FREE:
    - aluop_i ∈ {`EXE_DIV_OP, `EXE_DIVU_OP} and reg2_i==0 → BY_ZERO.
    - Same ops, reg2_i≠0 → ON. Latch operands (absolute values for DIV) and latch the sign flags.
    - stallreq_o=1 in the issue cycle.
  - BY_ZERO: result 0/0; next state END; stallreq_o=1.
  - ON:
    - One restoring step per cycle: shift the partial remainder, trial-subtract, set the quotient bit.
    - Counter runs 0..DIV_CYCLES-1; after the last step → END.
    - stallreq_o=1.
  - END:
    - stallreq_o=0, whilo_o=1.
    - hi_o/lo_o show the final remainder/quotient.
    - Next state FREE unconditionally. The pipeline advances on this edge, so the held DIV is not reissued.
- Signed DIV sign fix-up:
  - Quotient is negated when the dividend and divisor signs differ.
  - Remainder takes the dividend's sign. Example: -7/2 gives q=-3, r=-1.
  - 0x80000000/-1 gives q=0x80000000, r=0 (no trap).
- Latency: issue cycle T; stallreq_o is high T..T+32; END is at T+33. Divide by zero ends at T+2.
- hi_o/lo_o hold their last value outside END. whilo_o is high only in END.
- rst asserted in any state → FREE next edge: stall dropped, no whilo, counter cleared.
- Operands change while stallreq_o=1 (illegal upstream): ignored, because operands are latched at issue.

Optional Feature:
- Macro EX_DIV_ANNUL_EN.
- Defined:
  - Adds input annul_i (1 bit).
  - annul_i=1 in ON or BY_ZERO → FREE next edge, with stallreq_o=0 on that next cycle and no whilo_o pulse.
  - annul_i in FREE or END has no effect.
- Undefined: no port; the division always completes.

Decomposition:
- Shared package/define additions:
  - `EXE_DIV_OP, `EXE_DIVU_OP
  - divider state encodings (2 bits)
  - `DivResultBus (64-bit {hi,lo})
  - existing `EXE_*_OP / `EXE_RES_* codes, reused unchanged
- Sub-module div_unit: FSM, counter, restoring iteration and sign fix-up.
  - Ports: clk, rst, signed_i, start_i, op1_i, op2_i, annul_i, result_o[63:0], ready_o, busy_o.
  - ex_stage instantiates it and maps ready_o→whilo_o and busy_o→stallreq_o.

Test Plan:
- OR with reg1=0x0000F0F0, reg2=0x00FF00FF, wd=5, wreg=1 → wdata_o=0x00FFF0FF, wd_o=5, wreg_o=1, same cycle; NOR of the same operands → 0xFF000F00.
- SRA with reg1=4, reg2=0x80000010 → 0xF8000001; SRL gives 0x08000001; SLL with amount 0 gives 0x80000010.
- DIVU 100/7 → stallreq_o high for 33 cycles, then whilo_o=1 for one cycle with lo_o=14, hi_o=2, wreg_o=0.
- DIV -7/2 → lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- DIV x/0 → stallreq_o high for 2 cycles, then whilo_o=1 with hi_o=lo_o=0.
- rst pulsed at iteration 10 → stallreq_o=0 and whilo_o=0 next cycle; a new DIVU 9/3 then completes with lo_o=3, hi_o=0. With EX_DIV_ANNUL_EN, annul_i at iteration 10 gives the same result.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - opcodes, result classes and divider types for the execute stage
package ex_stage_pkg;

    localparam logic [7:0] EXE_NOP_OP  = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP  = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP   = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b00000011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b00011010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b00011011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    // {hi, lo} = {remainder, quotient}
    typedef logic [63:0] div_result_t;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider with sign fix-up, one quotient bit per cycle
module div_unit
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_i,
    input  logic        start_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        annul_i,
    output div_result_t result_o,
    output logic        ready_o,
    output logic        busy_o
);

    localparam int CNT_W = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_CYCLES - 1);

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_rem;
    logic [31:0]      r_quo;
    logic [31:0]      r_divisor;
    logic             r_neg_q;
    logic             r_neg_r;
    div_result_t      r_result;

    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_take;
    logic [31:0] w_rem_next;
    logic [31:0] w_quo_next;
    logic [31:0] w_abs1;
    logic [31:0] w_abs2;

    // The divisor is at most 2^32-1, so a 33-bit trial subtract yields a clean borrow bit.
    assign w_shift    = {r_rem, r_quo[31]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_take     = ~w_diff[32];
    assign w_rem_next = w_take ? w_diff[31:0] : w_shift[31:0];
    assign w_quo_next = {r_quo[30:0], w_take};
    assign w_abs1     = (signed_i && op1_i[31]) ? -op1_i : op1_i;
    assign w_abs2     = (signed_i && op2_i[31]) ? -op2_i : op2_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= DIV_FREE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_result  <= '0;
        end else begin
            case (r_state)
                DIV_FREE: begin
                    if (start_i) begin
                        if (op2_i == 32'd0) begin
                            r_state <= DIV_BY_ZERO;
                        end else begin
                            r_state   <= DIV_ON;
                            r_cnt     <= '0;
                            r_rem     <= '0;
                            r_quo     <= w_abs1;
                            r_divisor <= w_abs2;
                            r_neg_q   <= signed_i & (op1_i[31] ^ op2_i[31]);
                            r_neg_r   <= signed_i & op1_i[31];
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    if (annul_i) begin
                        r_state <= DIV_FREE;
                    end else begin
                        r_result <= '0;
                        r_state  <= DIV_END;
                    end
                end
                DIV_ON: begin
                    if (annul_i) begin
                        r_state <= DIV_FREE;
                        r_cnt   <= '0;
                    end else begin
                        r_rem <= w_rem_next;
                        r_quo <= w_quo_next;
                        if (r_cnt == LAST_STEP) begin
                            r_state  <= DIV_END;
                            r_cnt    <= '0;
                            r_result <= {r_neg_r ? -w_rem_next : w_rem_next,
                                         r_neg_q ? -w_quo_next : w_quo_next};
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= DIV_FREE;
            endcase
        end
    end

    // Issue-cycle stall is combinational so the upstream stages freeze on the DIV itself.
    assign busy_o   = ((r_state == DIV_FREE) && start_i) || (r_state == DIV_BY_ZERO) ||
                      (r_state == DIV_ON);
    assign ready_o  = (r_state == DIV_END);
    assign result_o = r_result;

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS32 execute stage: logic/shift datapath plus stalling divider (EX_DIV_ANNUL_EN adds annul_i)
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
`ifdef EX_DIV_ANNUL_EN
    input  logic        annul_i,
`endif
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    logic [31:0] w_logic;
    logic [31:0] w_shift;
    logic        w_is_div;
    logic        w_annul;
    logic        w_ready;
    logic        w_busy;
    div_result_t w_div_result;

`ifdef EX_DIV_ANNUL_EN
    assign w_annul = annul_i;
`else
    assign w_annul = 1'b0;
`endif

    assign w_is_div = is_div_op(aluop_i);

    div_unit #(
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .signed_i (aluop_i == EXE_DIV_OP),
        .start_i  (w_is_div),
        .op1_i    (reg1_i),
        .op2_i    (reg2_i),
        .annul_i  (w_annul),
        .result_o (w_div_result),
        .ready_o  (w_ready),
        .busy_o   (w_busy)
    );

    always_comb begin
        w_logic = '0;
        case (aluop_i)
            EXE_OR_OP:  w_logic = reg1_i | reg2_i;
            EXE_AND_OP: w_logic = reg1_i & reg2_i;
            EXE_XOR_OP: w_logic = reg1_i ^ reg2_i;
            EXE_NOR_OP: w_logic = ~(reg1_i | reg2_i);
            default:    w_logic = '0;
        endcase
    end

    always_comb begin
        w_shift = '0;
        case (aluop_i)
            EXE_SLL_OP: w_shift = reg2_i << reg1_i[4:0];
            EXE_SRL_OP: w_shift = reg2_i >> reg1_i[4:0];
            EXE_SRA_OP: w_shift = $unsigned($signed(reg2_i) >>> reg1_i[4:0]);
            default:    w_shift = '0;
        endcase
    end

    always_comb begin
        wd_o       = rst ? 5'd0 : wd_i;
        wreg_o     = rst ? 1'b0 : (wreg_i & ~w_is_div);
        whilo_o    = rst ? 1'b0 : w_ready;
        stallreq_o = rst ? 1'b0 : w_busy;
        hi_o       = rst ? 32'd0 : w_div_result[63:32];
        lo_o       = rst ? 32'd0 : w_div_result[31:0];
        wdata_o    = '0;
        if (!rst) begin
            case (alusel_i)
                EXE_RES_LOGIC: wdata_o = w_logic;
                EXE_RES_SHIFT: wdata_o = w_shift;
                default:       wdata_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage datapath and divider
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop = EXE_NOP_OP;
    logic [2:0]  alusel = EXE_RES_NOP;
    logic [31:0] reg1 = '0;
    logic [31:0] reg2 = '0;
    logic [4:0]  wd = '0;
    logic        wreg = 1'b0;
`ifdef EX_DIV_ANNUL_EN
    logic        annul = 1'b0;
`endif
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .alusel_i   (alusel),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .wd_i       (wd),
        .wreg_i     (wreg),
`ifdef EX_DIV_ANNUL_EN
        .annul_i    (annul),
`endif
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          stalls;
    } div_exp_t;

    div_exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;

    function automatic div_exp_t model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        div_exp_t e;
        if (b == 32'd0) begin
            e.hi = '0; e.lo = '0; e.stalls = 2;
        end else begin
            e.stalls = 33;
            if (!sgn) begin
                e.lo = a / b; e.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                e.lo = 32'h8000_0000; e.hi = '0;
            end else begin
                e.lo = $signed(a) / $signed(b); e.hi = $signed(a) % $signed(b);
            end
        end
        return e;
    endfunction

    task automatic apply(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] d, input logic w);
        aluop = op; alusel = sel; reg1 = a; reg2 = b; wd = d; wreg = w;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] d, input logic w);
        @(posedge clk); #1;
        apply(op, sel, a, b, d, w);
    endtask

    task automatic issue_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        set_op(sgn ? EXE_DIV_OP : EXE_DIVU_OP, EXE_RES_NOP, a, b, 5'd9, 1'b1);
        sb.push_back(model(sgn, a, b));
    endtask

    // Counts stall cycles (including the issue cycle) until whilo_o, bounded.
    task automatic wait_whilo(output int stalls, output bit seen);
        stalls = 0; seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (whilo_o) seen = 1'b1;
            else if (stallreq_o) stalls++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        apply(EXE_OR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0000_FFFF, 5'd7, 1'b1);
        @(negedge clk);
        n_cmp++;
        if ({wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got wd=%0d wreg=%0b wdata=%h whilo=%0b hi=%h lo=%h stall=%0b, want all 0",
                     wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o);
        end
        apply(EXE_DIVU_OP, EXE_RES_NOP, 32'd5, 32'd1, 5'd1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_div_stall: got stall=%0b whilo=%0b, want 0/0", stallreq_o, whilo_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        apply(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0);
    endtask

    task automatic test_logic;
        logic [7:0]  ops [4]  = '{EXE_OR_OP, EXE_NOR_OP, EXE_AND_OP, EXE_XOR_OP};
        logic [31:0] exps [4] = '{32'h00FF_F0FF, 32'hFF00_0F00, 32'h0000_00F0, 32'h00FF_F00F};
        for (int i = 0; i < 4; i++) begin
            set_op(ops[i], EXE_RES_LOGIC, 32'h0000_F0F0, 32'h00FF_00FF, 5'd5, 1'b1);
            @(negedge clk);
            n_cmp++;
            if (wdata_o !== exps[i] || wd_o !== 5'd5 || wreg_o !== 1'b1) begin
                n_bad++;
                $display("FAIL logic_%0d: got wdata=%h wd=%0d wreg=%0b, want %h/5/1",
                         i, wdata_o, wd_o, wreg_o, exps[i]);
            end
        end
        set_op(8'hEE, EXE_RES_LOGIC, 32'h1234_5678, 32'h1, 5'd2, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (wdata_o !== 32'd0) begin
            n_bad++;
            $display("FAIL logic_unknown_op: got %h want 0", wdata_o);
        end
    endtask

    task automatic test_shift;
        logic [7:0]  ops [4]  = '{EXE_SRA_OP, EXE_SRL_OP, EXE_SLL_OP, EXE_SLL_OP};
        logic [31:0] amt [4]  = '{32'd4, 32'd4, 32'd0, 32'hFFFF_FFE4};
        logic [31:0] exps [4] = '{32'hF800_0001, 32'h0800_0001, 32'h8000_0010, 32'h0000_0100};
        for (int i = 0; i < 4; i++) begin
            set_op(ops[i], EXE_RES_SHIFT, amt[i], 32'h8000_0010, 5'd12, 1'b1);
            @(negedge clk);
            n_cmp++;
            if (wdata_o !== exps[i]) begin
                n_bad++;
                $display("FAIL shift_%0d: got %h want %h", i, wdata_o, exps[i]);
            end
        end
        set_op(EXE_OR_OP, EXE_RES_NOP, 32'hFF, 32'hFF, 5'd1, 1'b1);
        @(negedge clk);
        n_cmp++;
        if (wdata_o !== 32'd0) begin
            n_bad++;
            $display("FAIL alusel_nop: got %h want 0", wdata_o);
        end
    endtask

    task automatic test_divu;
        int st; bit seen; div_exp_t e;
        issue_div(1'b0, 32'd100, 32'd7);
        wait_whilo(st, seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || st != e.stalls) begin
            n_bad++;
            $display("FAIL divu_latency: got stalls=%0d seen=%0b want stalls=%0d", st, seen, e.stalls);
        end
        n_cmp++;
        if (lo_o !== e.lo || hi_o !== e.hi || wreg_o !== 1'b0) begin
            n_bad++;
            $display("FAIL divu_result: got lo=%h hi=%h wreg=%0b want lo=%h hi=%h wreg=0",
                     lo_o, hi_o, wreg_o, e.lo, e.hi);
        end
        apply(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0);
        @(negedge clk);
        n_cmp++;
        if (whilo_o !== 1'b0 || stallreq_o !== 1'b0 || lo_o !== e.lo || hi_o !== e.hi) begin
            n_bad++;
            $display("FAIL divu_after: got whilo=%0b stall=%0b lo=%h hi=%h want 0/0 held %h/%h",
                     whilo_o, stallreq_o, lo_o, hi_o, e.lo, e.hi);
        end
    endtask

    task automatic test_div_signed;
        logic [31:0] as [3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'h0000_0007};
        logic [31:0] bs [3] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        int st; bit seen; div_exp_t e;
        for (int i = 0; i < 3; i++) begin
            issue_div(1'b1, as[i], bs[i]);
            wait_whilo(st, seen);
            e = sb.pop_front();
            n_cmp++;
            if (!seen || st != e.stalls || lo_o !== e.lo || hi_o !== e.hi) begin
                n_bad++;
                $display("FAIL div_signed_%0d: got stalls=%0d lo=%h hi=%h want stalls=%0d lo=%h hi=%h",
                         i, st, lo_o, hi_o, e.stalls, e.lo, e.hi);
            end
            apply(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0);
        end
    endtask

    task automatic test_div_zero;
        int st; bit seen; div_exp_t e;
        issue_div(1'b1, 32'd1234, 32'd0);
        wait_whilo(st, seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || st != e.stalls || lo_o !== e.lo || hi_o !== e.hi) begin
            n_bad++;
            $display("FAIL div_by_zero: got stalls=%0d seen=%0b lo=%h hi=%h want stalls=%0d lo=%h hi=%h",
                     st, seen, lo_o, hi_o, e.stalls, e.lo, e.hi);
        end
        apply(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0);
    endtask

    task automatic test_back_to_back;
        int st; bit seen; div_exp_t e;
        issue_div(1'b0, 32'hFFFF_FFFF, 32'd10);
        for (int k = 0; k < 2; k++) begin
            wait_whilo(st, seen);
            e = sb.pop_front();
            n_cmp++;
            if (!seen || st != e.stalls || lo_o !== e.lo || hi_o !== e.hi) begin
                n_bad++;
                $display("FAIL back_to_back_%0d: got stalls=%0d lo=%h hi=%h want stalls=%0d lo=%h hi=%h",
                         k, st, lo_o, hi_o, e.stalls, e.lo, e.hi);
            end
            if (k == 0) begin
                apply(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FF9C, 32'd7, 5'd9, 1'b1);
                sb.push_back(model(1'b1, 32'hFFFF_FF9C, 32'd7));
            end else begin
                apply(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0);
            end
        end
    endtask

    task automatic test_rst_abort;
        int st; bit seen; div_exp_t e;
        set_op(EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd9, 1'b1);
        repeat (11) @(negedge clk);
        rst = 1'b1;
        apply(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_abort: got stall=%0b whilo=%0b want 0/0", stallreq_o, whilo_o);
        end
        issue_div(1'b0, 32'd9, 32'd3);
        wait_whilo(st, seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || st != e.stalls || lo_o !== e.lo || hi_o !== e.hi) begin
            n_bad++;
            $display("FAIL rst_abort_redo: got stalls=%0d lo=%h hi=%h want stalls=%0d lo=%h hi=%h",
                     st, lo_o, hi_o, e.stalls, e.lo, e.hi);
        end
        apply(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0);
    endtask

`ifdef EX_DIV_ANNUL_EN
    task automatic test_annul;
        int st; bit seen; div_exp_t e;
        set_op(EXE_DIVU_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd9, 1'b1);
        repeat (11) @(negedge clk);
        annul = 1'b1;
        apply(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0);
        @(posedge clk); #1;
        annul = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) begin
            n_bad++;
            $display("FAIL annul_abort: got stall=%0b whilo=%0b want 0/0", stallreq_o, whilo_o);
        end
        issue_div(1'b0, 32'd9, 32'd3);
        wait_whilo(st, seen);
        e = sb.pop_front();
        n_cmp++;
        if (!seen || st != e.stalls || lo_o !== e.lo || hi_o !== e.hi) begin
            n_bad++;
            $display("FAIL annul_redo: got stalls=%0d lo=%h hi=%h want stalls=%0d lo=%h hi=%h",
                     st, lo_o, hi_o, e.stalls, e.lo, e.hi);
        end
        apply(EXE_NOP_OP, EXE_RES_NOP, '0, '0, '0, 1'b0);
    endtask
`endif

    initial begin
        test_reset;
        test_logic;
        test_shift;
        test_divu;
        test_div_signed;
        test_div_zero;
        test_back_to_back;
        test_rst_abort;
`ifdef EX_DIV_ANNUL_EN
        test_annul;
`endif
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
